synchronization: RTL

SYNCHRONIZATION -- requirements
Module: synchronization

---
 rtl/synchronization_pkg.sv | 100 ++++++++++
 rtl/synchronization_cg_classify.sv | 51 +++++
 rtl/synchronization.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/synchronization_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synchronization_pkg
//  Description : Shared 1000BASE-X code-group constants used by the transmit,
//                encoder and receive blocks. It holds the 8-bit octets, the
//                10-bit code-groups in both running disparities, the comma
//                patterns, the synchronization state encoding and a table
//                lookup helper.
//                Bit order for 10-bit groups: bit 9 = 'a' ... bit 0 = 'j'.
//                Suffix _N is the RD- column and _P is the RD+ column.
//  Revision    : 1.0  initial release
// ============================================================================
package synchronization_pkg;

    // Unencoded octets for the code-groups below.
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_K27_7 = 8'hFB;
    localparam logic [7:0] OCT_K29_7 = 8'hFD;
    localparam logic [7:0] OCT_K23_7 = 8'hF7;
    localparam logic [7:0] OCT_D5_6  = 8'hC5;
    localparam logic [7:0] OCT_D16_2 = 8'h50;

    // Special code-groups.
    localparam logic [9:0] CG_K28_5_N = 10'b0011111010;
    localparam logic [9:0] CG_K28_5_P = 10'b1100000101;
    localparam logic [9:0] CG_K27_7_N = 10'b1101101000;
    localparam logic [9:0] CG_K27_7_P = 10'b0010010111;
    localparam logic [9:0] CG_K29_7_N = 10'b1011101000;
    localparam logic [9:0] CG_K29_7_P = 10'b0100010111;
    localparam logic [9:0] CG_K23_7_N = 10'b1110101000;
    localparam logic [9:0] CG_K23_7_P = 10'b0001010111;

    // Data code-groups. D5.6 is identical in both disparities.
    localparam logic [9:0] CG_D5_6    = 10'b1010010110;
    localparam logic [9:0] CG_D16_2_N = 10'b0110110101;
    localparam logic [9:0] CG_D16_2_P = 10'b1001000101;
    localparam logic [9:0] CG_D0_0_N  = 10'b1001110100;
    localparam logic [9:0] CG_D0_0_P  = 10'b0110001011;
    localparam logic [9:0] CG_D1_0_N  = 10'b0111010100;
    localparam logic [9:0] CG_D1_0_P  = 10'b1000101011;
    localparam logic [9:0] CG_D2_0_N  = 10'b1011010100;
    localparam logic [9:0] CG_D2_0_P  = 10'b0100101011;
    localparam logic [9:0] CG_D3_0_N  = 10'b1100011011;
    localparam logic [9:0] CG_D3_0_P  = 10'b1100010100;
    localparam logic [9:0] CG_D4_0_N  = 10'b1101010100;
    localparam logic [9:0] CG_D4_0_P  = 10'b0010101011;
    localparam logic [9:0] CG_D5_0_N  = 10'b1010011011;
    localparam logic [9:0] CG_D5_0_P  = 10'b1010010100;
    localparam logic [9:0] CG_D6_0_N  = 10'b0110011011;
    localparam logic [9:0] CG_D6_0_P  = 10'b0110010100;
    localparam logic [9:0] CG_D7_0_N  = 10'b1110001011;
    localparam logic [9:0] CG_D7_0_P  = 10'b0001110100;

    // Comma patterns on bits [9:3] (a..g).
    localparam logic [6:0] COMMA_PLUS  = 7'b0011111;
    localparam logic [6:0] COMMA_MINUS = 7'b1100000;

    typedef enum logic [9:0] {
        LOSS_OF_SYNC    = 10'b00_0000_0001,
        COMMA_DETECT_1  = 10'b00_0000_0010,
        ACQUIRE_SYNC_1  = 10'b00_0000_0100,
        COMMA_DETECT_2  = 10'b00_0000_1000,
        ACQUIRE_SYNC_2  = 10'b00_0001_0000,
        COMMA_DETECT_3  = 10'b00_0010_0000,
        SYNC_ACQUIRED_1 = 10'b00_0100_0000,
        SYNC_ACQUIRED_2 = 10'b00_1000_0000,
        SYNC_ACQUIRED_3 = 10'b01_0000_0000,
        SYNC_ACQUIRED_4 = 10'b10_0000_0000
    } sync_state_t;

    typedef struct packed {
        logic valid;
        logic is_k;
    } cg_class_t;

    // Table membership of a received code-group.
    function automatic cg_class_t cg_lookup(input logic [9:0] cg);
        cg_class_t c;
        c.valid = 1'b0;
        c.is_k  = 1'b0;
        case (cg)
            CG_K28_5_N, CG_K28_5_P, CG_K27_7_N, CG_K27_7_P,
            CG_K29_7_N, CG_K29_7_P, CG_K23_7_N, CG_K23_7_P: begin
                c.valid = 1'b1;
                c.is_k  = 1'b1;
            end
            CG_D5_6, CG_D16_2_N, CG_D16_2_P,
            CG_D0_0_N, CG_D0_0_P, CG_D1_0_N, CG_D1_0_P,
            CG_D2_0_N, CG_D2_0_P, CG_D3_0_N, CG_D3_0_P,
            CG_D4_0_N, CG_D4_0_P, CG_D5_0_N, CG_D5_0_P,
            CG_D6_0_N, CG_D6_0_P, CG_D7_0_N, CG_D7_0_P: begin
                c.valid = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/synchronization_cg_classify.sv
`default_nettype none
// ============================================================================
//  Module      : cg_classify
//  Description : Combinational code-group classifier: comma detection, table
//                validity, data/special split and (optionally) the disparity
//                of the group.
//  Ports       : i_cg        10-bit received code-group (bit 9 = 'a')
//                o_comma     bits [9:3] carry a comma pattern
//                o_valid     group is a member of the code-group table
//                o_is_d      valid data (non-K) group
//                o_disp_pos  group has more ones than zeros
//                o_disp_neg  group has more zeros than ones
//  Config      : SYNC_DISPARITY_CHECK_EN adds o_disp_pos / o_disp_neg.
//  Revision    : 1.0  initial release
// ============================================================================
module cg_classify
    import synchronization_pkg::*;
(
    input  logic [9:0] i_cg,
    output logic       o_comma,
    output logic       o_valid,
`ifdef SYNC_DISPARITY_CHECK_EN
    output logic       o_disp_pos,
    output logic       o_disp_neg,
`endif
    output logic       o_is_d
);

    cg_class_t w_class;

    assign w_class = cg_lookup(i_cg);
    assign o_comma = (i_cg[9:3] == COMMA_PLUS) || (i_cg[9:3] == COMMA_MINUS);
    assign o_valid = w_class.valid;
    assign o_is_d  = w_class.valid & ~w_class.is_k;

`ifdef SYNC_DISPARITY_CHECK_EN
    logic [3:0] w_ones;

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'd0, i_cg[i]};
        end
    end

    assign o_disp_pos = (w_ones > 4'd5);
    assign o_disp_neg = (w_ones < 4'd5);
`endif

endmodule
`default_nettype wire

// File: rtl/synchronization.sv
`default_nettype none
// ============================================================================
//  Module      : synchronization
//  Description : 1000BASE-X receive code-group synchronization. It registers
//                the PMA code-group to SUDI and tracks comma alignment and the
//                link state. rx_even and sync_status describe the group on SUDI.
//  Ports       : GTX_CLK        clock, rising edge
//                mr_main_reset  asynchronous active-high reset
//                signal_detect  PMD reports optical signal present
//                PUDI[9:0]      raw code-group from PMA (bit 9 = 'a')
//                SUDI[9:0]      PUDI delayed one cycle
//                rx_even        even/odd position of the group on SUDI
//                sync_status    1 = synchronized, 0 = fail
//  Parameters  : GOOD_CGS_MAX   good groups needed to step back one level
//  Config      : SYNC_DISPARITY_CHECK_EN adds running-disparity checking.
//  Revision    : 1.0  initial release
// ============================================================================
module synchronization
    import synchronization_pkg::*;
#(
    parameter int GOOD_CGS_MAX = 3
)(
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       signal_detect,
    input  logic [9:0] PUDI,
    output logic [9:0] SUDI,
    output logic       rx_even,
    output logic       sync_status
);

    localparam logic [2:0] c_GOOD_CGS_MAX = 3'(GOOD_CGS_MAX);

    sync_state_t r_state;
    sync_state_t w_state_nxt;
    logic [9:0]  r_sudi;
    logic        r_rx_even;
    logic        w_rx_even_nxt;
    logic [1:0]  r_good_cgs;
    logic [1:0]  w_good_cgs_nxt;
    logic [2:0]  w_good_inc;
    logic        w_comma;
    logic        w_valid;
    logic        w_is_d;
    logic        w_rd_err;
    logic        w_bad;
    logic        w_d_ok;
    logic        w_bad_sa;

`ifdef SYNC_DISPARITY_CHECK_EN
    logic        w_disp_pos;
    logic        w_disp_neg;
    logic        r_rd_pos;
`endif

    cg_classify u_cg_classify (
        .i_cg       (PUDI),
        .o_comma    (w_comma),
        .o_valid    (w_valid),
`ifdef SYNC_DISPARITY_CHECK_EN
        .o_disp_pos (w_disp_pos),
        .o_disp_neg (w_disp_neg),
`endif
        .o_is_d     (w_is_d)
    );

`ifdef SYNC_DISPARITY_CHECK_EN
    // A +2 group is only legal at RD-, a -2 group only at RD+.
    assign w_rd_err = w_valid & ((w_disp_pos & r_rd_pos) | (w_disp_neg & ~r_rd_pos));

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_rd_pos <= 1'b0;
        end else if (w_valid && !w_rd_err) begin
            if (w_disp_pos) begin
                r_rd_pos <= 1'b1;
            end else if (w_disp_neg) begin
                r_rd_pos <= 1'b0;
            end
        end
    end
`else
    assign w_rd_err = 1'b0;
`endif

    assign w_bad      = ~w_valid | w_rd_err;
    assign w_d_ok     = w_is_d & ~w_rd_err;
    // r_rx_even = 1 means the incoming group would land in an odd slot.
    assign w_bad_sa   = w_bad | (w_comma & r_rx_even);
    assign w_good_inc = {1'b0, r_good_cgs} + 3'd1;

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_state    <= LOSS_OF_SYNC;
            r_sudi     <= '0;
            r_rx_even  <= 1'b0;
            r_good_cgs <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sudi     <= PUDI;
            r_rx_even  <= w_rx_even_nxt;
            r_good_cgs <= w_good_cgs_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rx_even_nxt  = ~r_rx_even;
        w_good_cgs_nxt = r_good_cgs;
        case (r_state)
            LOSS_OF_SYNC: begin
                if (w_comma && signal_detect) begin
                    w_state_nxt   = COMMA_DETECT_1;
                    w_rx_even_nxt = 1'b1;
                end
            end
            COMMA_DETECT_1: w_state_nxt = w_d_ok ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2: w_state_nxt = w_d_ok ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3: w_state_nxt = w_d_ok ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: begin
                if (w_bad || (w_comma && r_rx_even)) begin
                    w_state_nxt = LOSS_OF_SYNC;
                end else if (w_comma) begin
                    w_state_nxt   = (r_state == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
                    w_rx_even_nxt = 1'b1;
                end
            end
            SYNC_ACQUIRED_1: begin
                if (w_bad_sa) begin
                    w_state_nxt    = SYNC_ACQUIRED_2;
                    w_good_cgs_nxt = 2'd0;
                end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (w_bad_sa) begin
                    w_good_cgs_nxt = 2'd0;
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_nxt = SYNC_ACQUIRED_3;
                        SYNC_ACQUIRED_3: w_state_nxt = SYNC_ACQUIRED_4;
                        default:         w_state_nxt = LOSS_OF_SYNC;
                    endcase
                end else if (w_good_inc == c_GOOD_CGS_MAX) begin
                    w_good_cgs_nxt = 2'd0;
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_nxt = SYNC_ACQUIRED_1;
                        SYNC_ACQUIRED_3: w_state_nxt = SYNC_ACQUIRED_2;
                        default:         w_state_nxt = SYNC_ACQUIRED_3;
                    endcase
                end else begin
                    w_good_cgs_nxt = w_good_inc[1:0];
                end
            end
            default: w_state_nxt = LOSS_OF_SYNC;
        endcase
        // Loss of optical signal overrides every other transition.
        if (!signal_detect) begin
            w_state_nxt    = LOSS_OF_SYNC;
            w_good_cgs_nxt = 2'd0;
        end
    end

    assign SUDI        = r_sudi;
    assign rx_even     = r_rx_even;
    assign sync_status = (r_state == SYNC_ACQUIRED_1) || (r_state == SYNC_ACQUIRED_2) ||
                         (r_state == SYNC_ACQUIRED_3) || (r_state == SYNC_ACQUIRED_4);

endmodule
`default_nettype wire
